// File: rtl/apb_cfg_master_if.sv
// ---------------------------------------------------------------------------
// apb_cfg_master_if
//
// Bundles the two channels that apb_cfg_master sits between:
//   - the host-side command/response channel (valid/ready, one word per
//     command, one response per command)
//   - the APB3 initiator bus toward one compute-layer register port
//
// Modports:
//   master : the apb_cfg_master side (drives CMD_READY, RSP_*, PADDR, PSEL,
//            PENABLE, PWRITE, PWDATA)
//   slave  : the environment side (host issuing commands and the APB target
//            answering transfers)
//
// Parameters:
//   ADDR_WIDTH : width of CMD_ADDR and PADDR
//   DATA_WIDTH : width of CMD_WDATA, RSP_RDATA, PWDATA and PRDATA
// ---------------------------------------------------------------------------
interface apb_cfg_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    // Command channel
    logic                  CMD_VALID;
    logic                  CMD_READY;
    logic                  CMD_WRITE;
    logic [ADDR_WIDTH-1:0] CMD_ADDR;
    logic [DATA_WIDTH-1:0] CMD_WDATA;

    // Response channel
    logic                  RSP_VALID;
    logic                  RSP_READY;
    logic [DATA_WIDTH-1:0] RSP_RDATA;
    logic                  RSP_ERR;
    logic                  RSP_TIMEOUT;

    // APB3 bus
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA,
        input  RSP_READY,
        input  PRDATA, PREADY, PSLVERR,
        output CMD_READY,
        output RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    modport slave (
        output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA,
        output RSP_READY,
        output PRDATA, PREADY, PSLVERR,
        input  CMD_READY,
        input  RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

endinterface

// File: rtl/apb_cfg_master.sv
// ---------------------------------------------------------------------------
// apb_cfg_master
//
// Host-side configuration driver for the compute tops' APB register ports.
// Each accepted command becomes exactly one APB3 transfer (SETUP then
// ACCESS, waiting on PREADY), and the outcome is handed back on a
// valid/ready response channel. Only one transfer is ever outstanding:
// no new command is taken until the previous response has been consumed.
//
// Ports:
//   CLK    : single rising-edge clock
//   RESETN : asynchronous active-low reset; clears the FSM and every output
//            immediately, abandoning any in-flight transfer without response
//   bus    : apb_cfg_master_if.master
//              CMD_VALID/CMD_READY/CMD_WRITE/CMD_ADDR/CMD_WDATA  command in
//              RSP_VALID/RSP_READY/RSP_RDATA/RSP_ERR/RSP_TIMEOUT response out
//              PADDR/PSEL/PENABLE/PWRITE/PWDATA/PRDATA/PREADY/PSLVERR  APB
//
// Parameters:
//   ADDR_WIDTH     : address width (PADDR, CMD_ADDR)
//   DATA_WIDTH     : data width (PWDATA, PRDATA, CMD_WDATA, RSP_RDATA)
//   TIMEOUT_CYCLES : ACCESS cycles with PREADY low before the transfer is
//                    abandoned (timeout build only, must be >= 1)
//
// Build option:
//   APB_TIMEOUT_EN : when defined, a wait-state counter aborts a transfer
//                    whose slave never raises PREADY and reports it with
//                    RSP_ERR=1, RSP_TIMEOUT=1, RSP_RDATA=0. When undefined,
//                    ACCESS waits on PREADY forever and RSP_TIMEOUT is 0.
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module apb_cfg_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic               CLK,
    input logic               RESETN,
    apb_cfg_master_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic                  cmd_ready_q, cmd_ready_d;
    logic                  psel_q,      psel_d;
    logic                  penable_q,   penable_d;
    logic                  pwrite_q,    pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;

`ifdef APB_TIMEOUT_EN
    // Counter width follows the limit but is kept within 8..32 bits.
    localparam int TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W    = (TMO_BITS < 8) ? 8 : ((TMO_BITS > 32) ? 32 : TMO_BITS);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0] tmo_cnt_q,     tmo_cnt_d;
`else
    // TIMEOUT_CYCLES has no effect without the wait-state counter.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // State register. Reset lands in IDLE from anywhere, which is what
    // drops an in-flight transfer on the floor.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-output logic. Every output flop holds by default;
    // each state only touches what it changes. CMD_READY defaults low and is
    // raised only for cycles that will be spent in IDLE, so it comes up the
    // cycle after reset and the cycle after a response handshake.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = 1'b0;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
        rsp_timeout_d = rsp_timeout_q;
        tmo_cnt_d     = tmo_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                // Handshake uses the registered CMD_READY so the very first
                // IDLE cycle after reset (CMD_READY still 0) takes nothing.
                if (cmd_ready_q && bus.CMD_VALID) begin
                    state_d     = SETUP;
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    pwrite_d    = bus.CMD_WRITE;
                    paddr_d     = bus.CMD_ADDR;
                    pwdata_d    = bus.CMD_WDATA;
                end
            end

            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end

            ACCESS: begin
                if (bus.PREADY) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
                    rsp_err_d   = bus.PSLVERR;
`ifdef APB_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // This wait cycle is the TIMEOUT_CYCLES-th one: give up.
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    tmo_cnt_d     = tmo_cnt_q + 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                end
            end

            RESP: begin
                if (bus.RSP_READY) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output flops. Address, direction and write data are only loaded on
    // command acceptance, so they stay put through SETUP/ACCESS and keep
    // their last value afterwards.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    // Timeout flag and wait-state counter.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            rsp_timeout_q <= 1'b0;
            tmo_cnt_q     <= '0;
        end else begin
            rsp_timeout_q <= rsp_timeout_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    assign bus.RSP_TIMEOUT = rsp_timeout_q;
`else
    assign bus.RSP_TIMEOUT = 1'b0;
`endif

    assign bus.CMD_READY = cmd_ready_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_RDATA = rsp_rdata_q;
    assign bus.RSP_ERR   = rsp_err_q;

endmodule
